// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - key debounce, display mode FSM, edit cursor and blink blanking
// Optional inactivity auto-return to clock mode: define AUTO_RETURN_EN.

module clock_mode_ctrl #(
    parameter int DEBOUNCE_MS   = 20,
    parameter int BLINK_HALF_MS = 250,
    parameter int TIMEOUT_MS    = 10000
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_sel,
    input  logic       alarm_ring,
    output logic [1:0] mode,
    output logic [1:0] field,
    output logic       edit_en,
    output logic [7:0] blank,
    output logic       alarm_ack
);
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int BL_W = $clog2(BLINK_HALF_MS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_MS - 1);

    // bit 0 = mode key, bit 1 = select key
    logic [1:0]      key_raw;
    logic [1:0]      key_s1;
    logic [1:0]      key_s2;
    logic [1:0]      key_deb;
    logic [1:0]      key_deb_q;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign key_raw = {key_sel, key_mode};

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            key_s1    <= '0;
            key_s2    <= '0;
            key_deb   <= '0;
            key_deb_q <= '0;
            press     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            key_s1    <= key_raw;
            key_s2    <= key_s1;
            key_deb_q <= key_deb;
            press     <= key_deb & ~key_deb_q;
            for (int i = 0; i < 2; i++) begin
                if (key_s2[i] == key_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    key_deb[i] <= ~key_deb[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic [BL_W-1:0] blink_cnt;
    logic            phase;
    logic            phase_nxt;

    assign phase_nxt = (blink_cnt == BL_LAST) ? ~phase : phase;

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            blink_cnt <= (blink_cnt == BL_LAST) ? '0 : blink_cnt + BL_W'(1);
            phase     <= phase_nxt;
        end
    end

    logic [1:0] mode_nxt;
    logic [1:0] field_nxt;
    logic       edit_en_nxt;
    logic [7:0] blank_nxt;
    logic       alarm_ack_nxt;
    logic       timeout;

`ifdef AUTO_RETURN_EN
    localparam int TO_W = $clog2(TIMEOUT_MS + 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout = (idle_cnt == TO_W'(TIMEOUT_MS - 1));

    // Only counts while an edit mode is held with no key activity
    always_ff @(posedge clk_1khz) begin
        if (rst || !mode_nxt[0] || (|press) || (mode_nxt != mode)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end
`else
    // Edit modes are held until the next mode press
    assign timeout = (TIMEOUT_MS < 0);
`endif

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            mode      <= 2'd0;
            field     <= 2'd0;
            edit_en   <= 1'b0;
            blank     <= 8'h00;
            alarm_ack <= 1'b0;
        end else begin
            mode      <= mode_nxt;
            field     <= field_nxt;
            edit_en   <= edit_en_nxt;
            blank     <= blank_nxt;
            alarm_ack <= alarm_ack_nxt;
        end
    end

    // Ringing overrides everything; a mode press beats a same-cycle select press
    always_comb begin
        mode_nxt  = mode;
        field_nxt = field;
        if (alarm_ring) begin
            mode_nxt  = 2'd0;
            field_nxt = 2'd0;
        end else if (press[0]) begin
            mode_nxt  = mode + 2'd1;
            field_nxt = 2'd0;
        end else if (press[1] && mode[0]) begin
            field_nxt = (field == 2'd2) ? 2'd0 : field + 2'd1;
        end else if (timeout && mode[0]) begin
            mode_nxt  = 2'd0;
            field_nxt = 2'd0;
        end
    end

    always_comb begin
        blank_nxt     = 8'h00;
        edit_en_nxt   = mode_nxt[0] && !alarm_ring;
        alarm_ack_nxt = alarm_ring && (|press);
        if (alarm_ring) begin
            blank_nxt = phase_nxt ? 8'hFF : 8'h00;
        end else if (mode_nxt[0] && phase_nxt) begin
            blank_nxt = 8'h03 << {field_nxt, 1'b0};
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - table-driven and randomized check of clock_mode_ctrl against a behavioural model

module tb_clock_mode_ctrl;
    localparam int D  = 4;
    localparam int BH = 8;
    localparam int T  = 50;

    logic       clk_1khz = 1'b0;
    logic       rst = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_sel = 1'b0;
    logic       alarm_ring = 1'b0;
    logic [1:0] mode;
    logic [1:0] field;
    logic       edit_en;
    logic [7:0] blank;
    logic       alarm_ack;

    clock_mode_ctrl #(.DEBOUNCE_MS(D), .BLINK_HALF_MS(BH), .TIMEOUT_MS(T)) dut (
        .clk_1khz  (clk_1khz),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_sel   (key_sel),
        .alarm_ring(alarm_ring),
        .mode      (mode),
        .field     (field),
        .edit_en   (edit_en),
        .blank     (blank),
        .alarm_ack (alarm_ack)
    );

    always #5 clk_1khz = ~clk_1khz;

    int vectors = 0;
    int miscompares = 0;
    int ack_seen = 0;
    int b30_seen = 0;

    // Reference model: raw key history per edge since reset, press actions as scheduled edge numbers
    bit hm[$];
    bit hs[$];
    int qm[$];
    int qs[$];
    bit dm = 0;
    bit ds = 0;
    int k = -1;
    int last = 0;
    int m_mode = 0;
    int m_field = 0;
    int m_blank = 0;
    bit m_edit = 0;
    bit m_ack = 0;

    function automatic bit flips(input bit is_sel, input bit level);
        for (int j = 0; j < D; j++) begin
            int idx;
            bit v;
            idx = k - 2 - j;
            v = 1'b0;
            if (idx >= 0) v = is_sel ? hs[idx] : hm[idx];
            if (v == level) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit km, input bit ks, input bit ar);
        bit pm;
        bit ps;
        int phase;
        if (r) begin
            hm.delete(); hs.delete(); qm.delete(); qs.delete();
            dm = 0; ds = 0; k = -1; last = 0;
            m_mode = 0; m_field = 0; m_blank = 0; m_edit = 0; m_ack = 0;
            return;
        end
        k++;
        hm.push_back(km);
        hs.push_back(ks);
        if (flips(1'b0, dm)) begin dm = !dm; if (dm) qm.push_back(k + 2); end
        if (flips(1'b1, ds)) begin ds = !ds; if (ds) qs.push_back(k + 2); end
        pm = 0;
        ps = 0;
        if (qm.size() > 0 && qm[0] == k) begin pm = 1; void'(qm.pop_front()); end
        if (qs.size() > 0 && qs[0] == k) begin ps = 1; void'(qs.pop_front()); end
        m_ack = 0;
        if (ar) begin
            m_ack = pm || ps; m_mode = 0; m_field = 0;
        end else if (pm) begin
            m_mode = (m_mode + 1) % 4; m_field = 0; last = k;
        end else if (m_mode % 2 == 1 && ps) begin
            m_field = (m_field + 1) % 3; last = k;
        end
`ifdef AUTO_RETURN_EN
        else if (m_mode % 2 == 1 && k - last == T) begin
            m_mode = 0; m_field = 0;
        end
`endif
        phase = ((k + 1) / BH) % 2;
        if (ar) m_blank = phase ? 255 : 0;
        else if (m_mode % 2 == 1 && phase == 1) m_blank = 3 << (2 * m_field);
        else m_blank = 0;
        m_edit = (m_mode % 2 == 1) && !ar;
    endtask

    task automatic step(input bit r, input bit km, input bit ks, input bit ar);
        rst = r; key_mode = km; key_sel = ks; alarm_ring = ar;
        @(posedge clk_1khz);
        model_edge(r, km, ks, ar);
        #1;
        vectors++;
        if (mode !== 2'(m_mode) || field !== 2'(m_field) || edit_en !== m_edit ||
            blank !== 8'(m_blank) || alarm_ack !== m_ack) begin
            miscompares++;
            $display("FAIL model t=%0t got mode=%0d field=%0d edit=%0b blank=%02h ack=%0b want mode=%0d field=%0d edit=%0b blank=%02h ack=%0b",
                     $time, mode, field, edit_en, blank, alarm_ack, m_mode, m_field, m_edit, m_blank, m_ack);
        end
        if (alarm_ack === 1'b1) ack_seen++;
        if (blank === 8'h30) b30_seen++;
    endtask

    task automatic check_int(input string name, input int row, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL row%0d %s got=%0d want=%0d", row, name, got, want);
        end
    endtask

    typedef struct {
        bit r; bit km; bit ks; bit ar;
        int cyc; int mode; int field; int blank; int acks; int b30;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit km, input bit ks, input bit ar, input int cyc,
                                input int md, input int fd, input int bl, input int ac, input int b3);
        vec_t v;
        v.r = r; v.km = km; v.ks = ks; v.ar = ar; v.cyc = cyc;
        v.mode = md; v.field = fd; v.blank = bl; v.acks = ac; v.b30 = b3;
        return v;
    endfunction

    task automatic press_rows(input bit km, input bit ks, input int md, input int fd);
        tbl.push_back(mk(0, km, ks, 0, 10, md, fd, -1, -1, -1));
        tbl.push_back(mk(0, 0, 0, 0, 10, md, fd, -1, -1, -1));
    endtask

    initial begin
        int timeout_mode;
`ifdef AUTO_RETURN_EN
        timeout_mode = 0;
`else
        timeout_mode = 1;
`endif
        tbl.push_back(mk(1, 0, 0, 0, 2,   0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 0, 7,   0, 0, -1, -1, -1));
        tbl.push_back(mk(1, 1, 0, 0, 1,   0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 0, 0, 0, 10,  0, 0, -1, -1, -1));
        tbl.push_back(mk(0, 0, 0, 0, 100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 3,   0, 0, -1, -1, -1));
        tbl.push_back(mk(0, 0, 0, 0, 10,  0, 0, -1, -1, -1));
        tbl.push_back(mk(0, 1, 0, 0, 7,   0, 0, -1, -1, -1));
        tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, -1, -1, -1));
        tbl.push_back(mk(0, 1, 0, 0, 2,   1, 0, -1, -1, -1));
        tbl.push_back(mk(0, 0, 0, 0, 10,  1, 0, -1, -1, -1));
        press_rows(0, 1, 1, 1);
        press_rows(0, 1, 1, 2);
        tbl.push_back(mk(0, 0, 0, 0, 16,  1, 2, -1, -1, 8));
        press_rows(1, 0, 2, 0);
        press_rows(0, 1, 2, 0);
        press_rows(1, 0, 3, 0);
        press_rows(1, 0, 0, 0);
        press_rows(1, 0, 1, 0);
        press_rows(0, 1, 1, 1);
        press_rows(1, 1, 2, 0);
        press_rows(1, 0, 3, 0);
        tbl.push_back(mk(0, 0, 0, 1, 2,   0, 0, -1, 0, -1));
        tbl.push_back(mk(0, 0, 1, 1, 10,  0, 0, -1, 1, -1));
        tbl.push_back(mk(0, 0, 0, 1, 10,  0, 0, -1, 0, -1));
        tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, -1));
        tbl.push_back(mk(0, 1, 0, 0, 10,  1, 0, -1, -1, -1));
        tbl.push_back(mk(0, 0, 0, 0, 60,  timeout_mode, 0, -1, -1, -1));

        for (int i = 0; i < tbl.size(); i++) begin
            int a0;
            int b0;
            a0 = ack_seen;
            b0 = b30_seen;
            for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].r, tbl[i].km, tbl[i].ks, tbl[i].ar);
            if (tbl[i].mode >= 0)  check_int("mode", i, int'(mode), tbl[i].mode);
            if (tbl[i].field >= 0) check_int("field", i, int'(field), tbl[i].field);
            if (tbl[i].blank >= 0) check_int("blank", i, int'(blank), tbl[i].blank);
            if (tbl[i].acks >= 0)  check_int("ack_pulses", i, ack_seen - a0, tbl[i].acks);
            if (tbl[i].b30 >= 0)   check_int("blank30_cycles", i, b30_seen - b0, tbl[i].b30);
        end

        for (int seg = 0; seg < 300; seg++) begin
            bit rkm;
            bit rks;
            bit rar;
            bit rr;
            int len;
            rkm = 1'($urandom_range(0, 1));
            rks = 1'($urandom_range(0, 1));
            rar = ($urandom_range(0, 9) == 0);
            rr  = ($urandom_range(0, 49) == 0);
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) step(rr && c == 0, rkm, rks, rar);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
